instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//   Fetch stage directly upstream of the control unit. Holds the PC and requests
//   instructions from instruction memory over a ready handshake. Presents a decoded
//   instruction (opCode, funct, imm) to the control unit/datapath until retirement,
//   then advances the PC sequentially or to the branch target. Stops on HALT or
//   on a memory timeout.
// PARAMETERS
//   PC_WIDTH     32     PC and imem address width (bits)
//   RESET_PC     0      PC after reset; bits [1:0] forced to 0
//   HALT_OPCODE  6'h3F  opcode that halts fetch after it retires
//   TIMEOUT      15     max wait cycles for imem_ready before error (>=1)
// PORTS
//   clk           in   1         clock; all state updates on rising edge
//   rst           in   1         reset, synchronous, active-low
//   imem_req      out  1         fetch request to instruction memory
//   imem_addr     out  PC_WIDTH  fetch address; always equals pc
//   imem_rdata    in   32        instruction word; valid when imem_req & imem_ready
//   imem_ready    in   1         memory accepts request and returns data this cycle
//   retire        in   1         1-cycle pulse: current instruction has completed
//   branch_taken  in   1         Branch & ALU zero; sampled only with retire
//   instr         out  32        held instruction word
//   opCode        out  6         instr[31:26], to control unit
//   funct         out  6         instr[5:0], to control unit
//   imm           out  16        instr[15:0]
//   instr_valid   out  1         instr/opCode/funct/imm are valid
//   pc            out  PC_WIDTH  address of the held instruction
//   halted        out  1         HALT retired; fetch stopped
//   fetch_err     out  1         imem timeout; fetch stopped
// BEHAVIOUR
//   Reset (rst==0 at edge): pc=RESET_PC, instr=0, instr_valid=0, imem_req=0,
//     halted=0, fetch_err=0, wait_cnt=0, state=FETCH. Overrides all other inputs;
//     an outstanding request is dropped and its data is ignored.
//   FSM states: FETCH, ISSUE, HALT, ERROR.
//   FETCH: imem_req=1 (combinational from state). When imem_ready=1: instr<=imem_rdata,
//     instr_valid<=1, wait_cnt<=0, ->ISSUE. Otherwise wait_cnt++; if wait_cnt==TIMEOUT-1
//     and no ready: fetch_err<=1, ->ERROR. Latency: word returned at edge N is visible
//     at N+1. First request occurs in the first cycle after reset release.
//   ISSUE: imem_req=0, instr held stable. On retire:
//     - instr_valid<=0.
//     - pc<=branch_taken ? pc+4+(sext(imm)<<2) : pc+4. Arithmetic is modulo 2^PC_WIDTH,
//       so wrap-around is silent.
//     - If opCode==HALT_OPCODE: halted<=1, ->HALT, pc is still updated. Else ->FETCH.
//     - The next request is asserted the cycle after retire.
//   HALT, ERROR: absorbing states. imem_req=0, instr_valid=0. Only reset exits.
//   Ignored inputs:
//     - retire outside ISSUE.
//     - branch_taken without retire.
//     - imem_ready/imem_rdata outside FETCH.
//   Simultaneous events:
//     - retire and branch_taken together: branch target is used.
//     - retire and rst==0 at the same edge: reset wins.
//   imem_rdata is captured only in FETCH; X on imem_rdata outside FETCH must not propagate.
//   opCode/funct/imm are slices of the instr register. They read 0 after reset, which
//   is the R-type/funct-0 encoding; the control unit qualifies on instr_valid.
// STRUCTURE
//   Shared package cpu_pkg:
//     - opcode/funct constants (R-type 6'h0, addi 6'h8, lw 6'h23, sw 6'h2b,
//       beq 6'h4, HALT 6'h3F)
//     - fetch_state_t enum {FETCH, ISSUE, HALT, ERROR}
//   Sub-module pc_next_logic (combinational): pc, imm, branch_taken -> next pc.
//     Reused by the later pipelined fetch stage.
// TESTING
//   1. Reset, imem_ready=1 constantly, rdata=32'h20080005 (addi), retire every ISSUE
//      -> imem_addr sequence 0,4,8; opCode=6'h08 while instr_valid=1.
//   2. pc=0x10 holding beq with imm=16'hFFFC, retire+branch_taken
//      -> next imem_addr=0x04. Same instruction with branch_taken=0 -> 0x14.
//   3. imem_ready held low for 3 cycles, then high -> no error; instr captured;
//      instr_valid rises on the following edge.
//      imem_ready held low for TIMEOUT cycles -> fetch_err=1, imem_req=0 permanently.
//   4. Retire of rdata=32'hFC000000 -> halted=1, no further imem_req.
//      Retire pulses while halted -> no change.
//   5. rst=0 during FETCH with imem_ready=1 in the same cycle -> instr stays 0,
//      pc=RESET_PC, first request in the cycle after release.
//   6. pc=32'hFFFFFFFC, sequential retire -> pc=0. Retire during FETCH -> pc unchanged.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode/funct encodings and the fetch-stage state type.
package cpu_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_HALT  = 6'h3F;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  typedef enum logic [1:0] {FETCH, ISSUE, HALT, ERROR} fetch_state_t;
endpackage

// File: rtl/instr_fetch_unit_pc_next.sv
// pc_next_logic: next-PC selection, sequential (pc+4) or branch target.
//   pc           in  current PC
//   imm          in  16-bit branch offset in words
//   branch_taken in  select branch target
//   pc_next      out next PC, modulo 2^PC_WIDTH
module pc_next_logic #(
  parameter int PC_WIDTH = 32
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [15:0]         imm,
  input  logic                branch_taken,
  output logic [PC_WIDTH-1:0] pc_next
);
  logic [PC_WIDTH-1:0] w_seq;
  logic [PC_WIDTH-1:0] w_off;
  assign w_seq   = pc + PC_WIDTH'(4);
  assign w_off   = PC_WIDTH'($signed(imm));
  assign pc_next = branch_taken ? w_seq + (w_off << 2) : w_seq;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: holds the PC, fetches one instruction over a ready
// handshake, presents it until retire, then advances; stops on HALT or timeout.
//   clk, rst (sync, active-low)
//   imem_req/imem_addr/imem_rdata/imem_ready  instruction memory handshake
//   retire, branch_taken                      completion of the held instruction
//   instr/opCode/funct/imm/instr_valid/pc     held instruction to control unit
//   halted, fetch_err                         terminal status
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                 PC_WIDTH    = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [5:0]         HALT_OPCODE = OP_HALT,
  parameter int                 TIMEOUT     = 15
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_rdata,
  input  logic                imem_ready,
  input  logic                retire,
  input  logic                branch_taken,
  output logic [31:0]         instr,
  output logic [5:0]          opCode,
  output logic [5:0]          funct,
  output logic [15:0]         imm,
  output logic                instr_valid,
  output logic [PC_WIDTH-1:0] pc,
  output logic                halted,
  output logic                fetch_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [PC_WIDTH-1:0] PC0 = {RESET_PC[PC_WIDTH-1:2], 2'b00};
  fetch_state_t        r_state, w_next;
  logic [PC_WIDTH-1:0] r_pc, w_pc_next;
  logic [31:0]         r_instr;
  logic                r_valid, r_halted, r_err;
  logic [CW-1:0]       r_wait;
  logic                w_last_wait;
  assign w_last_wait = r_wait == CW'(TIMEOUT - 1);
  pc_next_logic #(.PC_WIDTH(PC_WIDTH)) u_pc_next (
    .pc          (r_pc),
    .imm         (r_instr[15:0]),
    .branch_taken(branch_taken),
    .pc_next     (w_pc_next)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH:   w_next = imem_ready ? ISSUE : (w_last_wait ? ERROR : FETCH);
      ISSUE:   w_next = retire ? (r_instr[31:26] == HALT_OPCODE ? HALT : FETCH) : ISSUE;
      default: w_next = r_state;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= FETCH;
      r_pc     <= PC0;
      r_instr  <= '0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
      r_err    <= 1'b0;
      r_wait   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == FETCH) begin
        if (imem_ready) begin
          r_instr <= imem_rdata;
          r_valid <= 1'b1;
          r_wait  <= '0;
        end else if (w_last_wait) begin
          r_err <= 1'b1;
        end else begin
          r_wait <= r_wait + 1'b1;
        end
      end
      if (r_state == ISSUE && retire) begin
        r_valid  <= 1'b0;
        r_pc     <= w_pc_next;
        r_halted <= w_next == HALT;
      end
    end
  end
  // Gated by rst so no request is seen while reset is still held.
  assign imem_req    = rst && r_state == FETCH;
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instr       = r_instr;
  assign opCode      = r_instr[31:26];
  assign funct       = r_instr[5:0];
  assign imm         = r_instr[15:0];
  assign instr_valid = r_valid;
  assign halted      = r_halted;
  assign fetch_err   = r_err;
endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  localparam int TO = 15;
  localparam logic [31:0] A = 32'h20080005;
  localparam logic [31:0] B = 32'h1000FFFC;
  localparam logic [31:0] H = 32'hFC000000;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst, imem_req, imem_ready, retire, branch_taken, instr_valid, halted, fetch_err;
  logic [31:0] imem_addr, imem_rdata, instr, pc;
  logic [5:0]  opCode, funct;
  logic [15:0] imm;
  instr_fetch_unit #(.PC_WIDTH(32), .RESET_PC(32'h0), .HALT_OPCODE(6'h3F), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .retire(retire), .branch_taken(branch_taken), .instr(instr),
    .opCode(opCode), .funct(funct), .imm(imm), .instr_valid(instr_valid), .pc(pc),
    .halted(halted), .fetch_err(fetch_err)
  );
  int vecs = 0, miss = 0;
  // Reference: "holding" means an instruction is presented; otherwise fetching
  // unless stopped. PC moves only when a held instruction retires.
  logic [31:0] m_pc = '0, m_instr = '0;
  bit m_rst = 1'b0, m_hold = 1'b0, m_halt = 1'b0, m_err = 1'b0;
  int m_waits = 0;
  task automatic model_step(input bit r, rdy, input logic [31:0] rd, input bit ret, br);
    m_rst = r;
    if (!r) begin
      m_pc = '0; m_instr = '0; m_hold = 0; m_halt = 0; m_err = 0; m_waits = 0;
    end else if (m_halt || m_err) begin
    end else if (!m_hold) begin
      if (rdy) begin
        m_instr = rd; m_hold = 1; m_waits = 0;
      end else if (++m_waits >= TO) m_err = 1;
    end else if (ret) begin
      m_hold = 0;
      m_pc = 32'(longint'(m_pc) + 4 + (br ? 4 * longint'($signed(m_instr[15:0])) : 0));
      if (m_instr[31:26] == 6'h3F) m_halt = 1;
    end
  endtask
  task automatic chk(input string name, input logic [127:0] act, exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [127:0] dut_all();
    return {imem_req, imem_addr, instr, instr_valid, pc, halted, fetch_err, opCode, funct, imm};
  endfunction
  function automatic logic [127:0] model_all();
    return {m_rst & ~m_hold & ~m_halt & ~m_err, m_pc, m_instr, m_hold, m_pc, m_halt, m_err,
            m_instr[31:26], m_instr[5:0], m_instr[15:0]};
  endfunction
  task automatic cyc(input bit r, rdy, input logic [31:0] rd, input bit ret, br);
    rst = r; imem_ready = rdy; imem_rdata = rd; retire = ret; branch_taken = br;
    @(posedge clk);
    model_step(r, rdy, rd, ret, br);
    @(negedge clk);
    chk("model", dut_all(), model_all());
  endtask
  typedef struct {
    bit r, rdy; logic [31:0] rd; bit ret, br;
    bit e_req; logic [31:0] e_addr, e_instr; bit e_valid, e_halt, e_err;
  } vec_t;
  vec_t tbl[$];
  initial begin
    tbl.push_back('{0,1,A,0,0, 0,32'h00,32'h0,0,0,0});
    tbl.push_back('{1,0,0,0,0, 1,32'h00,32'h0,0,0,0});
    tbl.push_back('{1,1,A,0,0, 0,32'h00,A,1,0,0});
    tbl.push_back('{1,0,0,1,0, 1,32'h04,A,0,0,0});
    tbl.push_back('{1,1,A,0,0, 0,32'h04,A,1,0,0});
    tbl.push_back('{1,0,0,1,0, 1,32'h08,A,0,0,0});
    tbl.push_back('{1,1,A,0,0, 0,32'h08,A,1,0,0});
    tbl.push_back('{1,0,0,1,0, 1,32'h0C,A,0,0,0});
    tbl.push_back('{1,1,A,0,0, 0,32'h0C,A,1,0,0});
    tbl.push_back('{1,0,0,1,0, 1,32'h10,A,0,0,0});
    tbl.push_back('{1,1,B,0,0, 0,32'h10,B,1,0,0});
    tbl.push_back('{1,0,0,1,1, 1,32'h04,B,0,0,0});
    tbl.push_back('{1,1,B,0,0, 0,32'h04,B,1,0,0});
    tbl.push_back('{1,0,0,1,0, 1,32'h08,B,0,0,0});
    tbl.push_back('{1,1,A,0,0, 0,32'h08,A,1,0,0});
    tbl.push_back('{1,0,0,1,0, 1,32'h0C,A,0,0,0});
    tbl.push_back('{1,1,A,0,0, 0,32'h0C,A,1,0,0});
    tbl.push_back('{1,0,0,1,0, 1,32'h10,A,0,0,0});
    tbl.push_back('{1,1,B,0,0, 0,32'h10,B,1,0,0});
    tbl.push_back('{1,0,0,1,0, 1,32'h14,B,0,0,0});
    tbl.push_back('{1,1,H,0,0, 0,32'h14,H,1,0,0});
    tbl.push_back('{1,1,A,0,1, 0,32'h14,H,1,0,0});
    tbl.push_back('{1,0,0,1,0, 0,32'h18,H,0,1,0});
    tbl.push_back('{1,1,A,1,1, 0,32'h18,H,0,1,0});
    tbl.push_back('{1,1,A,0,0, 0,32'h18,H,0,1,0});
    tbl.push_back('{0,1,A,0,0, 0,32'h00,32'h0,0,0,0});
    tbl.push_back('{1,0,0,0,0, 1,32'h00,32'h0,0,0,0});
    tbl.push_back('{1,1,B,0,0, 0,32'h00,B,1,0,0});
    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].rdy, tbl[i].rd, tbl[i].ret, tbl[i].br);
      chk($sformatf("table[%0d]", i),
          128'({imem_req, imem_addr, instr, instr_valid, halted, fetch_err}),
          128'({tbl[i].e_req, tbl[i].e_addr, tbl[i].e_instr, tbl[i].e_valid, tbl[i].e_halt, tbl[i].e_err}));
    end
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
    chk("wait3_no_err", 128'({instr_valid, fetch_err, imem_req}), 128'(3'b001));
    cyc(1, 1, A, 0, 0);
    chk("wait3_capture", 128'({instr_valid, instr, fetch_err}), 128'({1'b1, A, 1'b0}));
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < TO - 1; i++) cyc(1, 0, 0, 0, 0);
    chk("timeout_minus1", 128'({fetch_err, imem_req}), 128'(2'b01));
    cyc(1, 0, 0, 0, 0);
    chk("timeout", 128'({fetch_err, imem_req}), 128'(2'b10));
    for (int i = 0; i < 5; i++) cyc(1, 1, A, 1, 0);
    chk("timeout_sticky", 128'({fetch_err, imem_req, instr_valid}), 128'(3'b100));
    cyc(0, 0, 0, 0, 0);
    cyc(1, 1, 32'h1000FFFE, 0, 0);
    cyc(1, 0, 0, 1, 1);
    chk("wrap_branch", 128'(pc), 128'(32'hFFFFFFFC));
    cyc(1, 0, 0, 1, 1);
    chk("retire_in_fetch", 128'({pc, imem_req}), 128'({32'hFFFFFFFC, 1'b1}));
    cyc(1, 1, A, 0, 0);
    cyc(1, 0, 0, 1, 0);
    chk("wrap_seq", 128'(imem_addr), 128'(32'h0));
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] op;
      bit r;
      case ($urandom_range(0, 9))
        0: op = 6'h3F; 1: op = 6'h04; 2: op = 6'h23; 3: op = 6'h2B; 4, 5: op = 6'h08;
        default: op = 6'h00;
      endcase
      r = (m_halt || m_err) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 99) != 0);
      cyc(r, $urandom_range(0, 9) < 6, {op, 26'($urandom)}, $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
